bitwise_oper_checker: RTL
=========================

BITWISE_OPER_CHECKER -- requirements
Module: bitwise_oper_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width.
REQ-002 SHALL have parameter LOG_DEPTH, default 256, error-log entries (power of 2); AW = ceil(log2(LOG_DEPTH)) = 8, computed by a constant function.
REQ-003 SHALL have parameter STOP_ON_ERR, default 0; 1 = halt intake after first mismatch.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  sample valid.
REQ-007 SHALL have port in_ready  out  1  checker accepts sample.
REQ-008 SHALL have port in_a, in_b  in  WIDTH  operands.
REQ-009 SHALL have port in_and, in_or, in_xor  in  WIDTH  claimed results.
REQ-010 SHALL have port clear  in  1  synchronous request: flush, zero counters, empty log.
REQ-011 SHALL have port log_rd_en  in  1  pop one log entry.
REQ-012 SHALL have port log_rd_data  out  51  {idx[15:0], flags[2:0] = {xor,or,and mismatch}, a[15:0], b[15:0]}.
REQ-013 SHALL have port log_empty, log_full, log_ovf  out  1 each  log status; ovf sticky.
REQ-014 SHALL have port pass_cnt, err_cnt  out  32 each  checked-sample counters.
REQ-015 SHALL have port halted  out  1  high in HALT state.

Function
REQ-016 Transfer SHALL occur only on a rising clk edge with in_valid && in_ready.
REQ-017 Stage 1 SHALL register the accepted sample and assign idx = a 16-bit sample index (wraps 0xFFFF->0).
REQ-018 Stage 2 SHALL recompute a&b, a|b, a^b and set each flag bit on mismatch; latency is 2 cycles from acceptance to counter update.
REQ-019 A sample with flags==0 SHALL increment pass_cnt; otherwise err_cnt. Both counters SHALL saturate at 0xFFFFFFFF.
REQ-020 A failing sample SHALL be pushed to the log FIFO in the same cycle err_cnt updates.
REQ-021 A push while full SHALL be dropped and set log_ovf, unless a pop occurs in the same cycle, in which case both pop and push SHALL proceed.
REQ-022 On log_rd_en && !log_empty, log_rd_data SHALL present the oldest entry in the following cycle and hold it until the next pop. log_rd_en when empty SHALL be ignored.
REQ-023 The FSM SHALL have states RUN, FLUSH, HALT, with in_ready = (state == RUN).
REQ-024 RUN->HALT SHALL occur when STOP_ON_ERR==1 and stage 2 flags != 0. Samples already in stage 1 SHALL still be checked.
REQ-025 RUN or HALT->FLUSH SHALL occur on clear. FLUSH SHALL hold until both stages are empty, then zero the counters, the index, the log pointers and log_ovf, and return to RUN.
REQ-026 clear asserted in FLUSH SHALL be ignored; clear takes priority over the error-to-HALT transition in the same cycle.
REQ-027 A log pop in the same cycle as FLUSH completion SHALL be discarded.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously enter RUN and hold in_ready=1 (rst_n high), halted=0, pass_cnt=err_cnt=0, idx=0, log_empty=1, log_full=0, log_ovf=0, log_rd_data=0, and both stages empty.
REQ-029 Reset mid-operation SHALL discard in-flight samples and log contents without emitting counter updates.

Structure
REQ-030 The shared package SHALL hold WIDTH, LOG_DEPTH, the clogb2 constant function, the FSM state encoding, and the log-entry field offsets.
REQ-031 The log SHALL be one sub-module, err_log_fifo: synchronous FIFO, registered read, count width AW+1.

Verification
REQ-032 Bench SHALL check: 10 correct samples (a=0x0001·n, b=0x0100·n) -> pass_cnt=10, err_cnt=0, log_empty=1.
REQ-033 Bench SHALL check: sample a=0x00FF, b=0x0F0F, in_xor=0x0000 -> err_cnt=1, log entry flags=3'b100, a=0x00FF, b=0x0F0F.
REQ-034 Bench SHALL check: 257 failing samples with no pops -> log_full=1, log_ovf=1, 256 entries, first idx=0.
REQ-035 Bench SHALL check: STOP_ON_ERR=1, failure at idx 5 with back-to-back valid -> halted=1, in_ready=0, idx 6 counted, then clear -> RUN, counters 0.
REQ-036 Bench SHALL check: full log with simultaneous pop and failing push -> log_ovf stays 0, count stays 256.
REQ-037 Bench SHALL check: rst_n low while samples are in both stages -> all outputs at reset values within the same cycle, no counter increments.

Source files
------------

// File: rtl/bitwise_oper_checker_pkg.sv
// Shared definitions for the bitwise operation checker.
// Holds the default operand width and log depth, the clogb2 constant function,
// the checker FSM state encoding and the bit offsets of a log entry:
//   {idx[15:0], flags[2:0] = {xor, or, and mismatch}, a[WIDTH-1:0], b[WIDTH-1:0]}
package bitwise_oper_checker_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned LOG_DEPTH = 256;

  localparam int unsigned IDX_W  = 16;
  localparam int unsigned FLAG_W = 3;

  // Flag bit positions inside the flags field.
  localparam int unsigned FLAG_AND = 0;
  localparam int unsigned FLAG_OR  = 1;
  localparam int unsigned FLAG_XOR = 2;

  // Log-entry field offsets for the default WIDTH.
  localparam int unsigned B_LSB     = 0;
  localparam int unsigned A_LSB     = WIDTH;
  localparam int unsigned FLAGS_LSB = 2 * WIDTH;
  localparam int unsigned IDX_LSB   = 2 * WIDTH + FLAG_W;
  localparam int unsigned LOG_W     = IDX_LSB + IDX_W;

  // Number of address bits needed to index 'value' entries.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1,
    StHalt  = 2'd2
  } state_e;

endpackage

// File: rtl/bitwise_oper_checker_err_log_fifo.sv
// err_log_fifo: synchronous FIFO holding failing-sample log entries.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear: empties the FIFO, zeroes rdata and ovf
//   push, wdata  write request and entry
//   pop          read request; rdata is registered and updates the cycle after
//   rdata        last popped entry, held until the next pop
//   empty, full  occupancy status
//   ovf          sticky: a push was dropped because the FIFO was full
module err_log_fifo
  import bitwise_oper_checker_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 51
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int unsigned AW = clogb2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic [Width-1:0] rdata_q;
  logic             ovf_q;
  logic             pop_eff, push_eff, push_drop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW + 1)'(Depth));

  // A pop frees a slot for a same-cycle push even when full; clear wins over both.
  assign pop_eff   = pop && !empty && !clr;
  assign push_eff  = push && (!full || pop_eff) && !clr;
  assign push_drop = push && full && !pop_eff && !clr;

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_eff) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_eff) begin
        rptr_q  <= rptr_q + AW'(1);
        rdata_q <= mem[rptr_q];
      end
      unique case ({push_eff, pop_eff})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign rdata = rdata_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/bitwise_oper_checker.sv
// bitwise_oper_checker: two-stage checker for claimed a&b, a|b, a^b results.
// Stage 1 registers an accepted sample and tags it with a 16-bit index;
// stage 2 holds the mismatch flags; counters and the error log update from stage 2.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                sample handshake (ready only in RUN)
//   in_a, in_b                       operands
//   in_and, in_or, in_xor            claimed results
//   clear                            flush pipeline, zero counters/index, empty log
//   log_rd_en/log_rd_data            pop interface of the error log
//   log_empty, log_full, log_ovf     log status (ovf sticky)
//   pass_cnt, err_cnt                saturating sample counters
//   halted                           high in HALT
module bitwise_oper_checker #(
  parameter int unsigned WIDTH       = bitwise_oper_checker_pkg::WIDTH,
  parameter int unsigned LOG_DEPTH   = bitwise_oper_checker_pkg::LOG_DEPTH,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_and,
  input  logic [WIDTH-1:0]     in_or,
  input  logic [WIDTH-1:0]     in_xor,
  input  logic                 clear,
  input  logic                 log_rd_en,
  output logic [bitwise_oper_checker_pkg::IDX_W + bitwise_oper_checker_pkg::FLAG_W
                + 2 * WIDTH - 1:0] log_rd_data,
  output logic                 log_empty,
  output logic                 log_full,
  output logic                 log_ovf,
  output logic [31:0]          pass_cnt,
  output logic [31:0]          err_cnt,
  output logic                 halted
);

  import bitwise_oper_checker_pkg::*;

  localparam int unsigned AW = clogb2(LOG_DEPTH);
  localparam int unsigned EW = IDX_W + FLAG_W + 2 * WIDTH;

  state_e           state_q;
  logic             ready_q, halted_q;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_and_q, s1_or_q, s1_xor_q;
  logic [IDX_W-1:0] s1_idx_q;

  logic             s2_valid_q;
  logic [2:0]       s2_flags_q;
  logic [WIDTH-1:0] s2_a_q, s2_b_q;
  logic [IDX_W-1:0] s2_idx_q;

  logic [IDX_W-1:0] idx_q;
  logic [31:0]      pass_q, err_q;

  logic             accept, s2_err, flush_done;
  logic [2:0]       s1_flags;
  logic [EW-1:0]    log_wdata;
  logic [AW:0]      unused_aw;

  assign accept     = in_valid && ready_q;
  assign s2_err     = s2_valid_q && (s2_flags_q != 3'b000);
  assign flush_done = (state_q == StFlush) && !s1_valid_q && !s2_valid_q;

  assign s1_flags[FLAG_AND] = ((s1_a_q & s1_b_q) != s1_and_q);
  assign s1_flags[FLAG_OR]  = ((s1_a_q | s1_b_q) != s1_or_q);
  assign s1_flags[FLAG_XOR] = ((s1_a_q ^ s1_b_q) != s1_xor_q);

  assign log_wdata = {s2_idx_q, s2_flags_q, s2_a_q, s2_b_q};
  assign unused_aw = '0;

  // Pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_and_q   <= '0;
      s1_or_q    <= '0;
      s1_xor_q   <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_flags_q <= '0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_idx_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_and_q <= in_and;
        s1_or_q  <= in_or;
        s1_xor_q <= in_xor;
        s1_idx_q <= idx_q;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_flags_q <= s1_flags;
        s2_a_q     <= s1_a_q;
        s2_b_q     <= s1_b_q;
        s2_idx_q   <= s1_idx_q;
      end
    end
  end

  // Sample index and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      pass_q <= '0;
      err_q  <= '0;
    end else if (flush_done) begin
      idx_q  <= '0;
      pass_q <= '0;
      err_q  <= '0;
    end else begin
      if (accept) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (s2_valid_q) begin
        if (s2_err) begin
          if (err_q != '1) err_q <= err_q + 32'd1;
        end else begin
          if (pass_q != '1) pass_q <= pass_q + 32'd1;
        end
      end
    end
  end

  // Control FSM; clear outranks the error-to-HALT transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      ready_q  <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (clear) begin
            state_q <= StFlush;
            ready_q <= 1'b0;
          end else if ((STOP_ON_ERR != 0) && s2_err) begin
            state_q  <= StHalt;
            ready_q  <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        StHalt: begin
          if (clear) begin
            state_q  <= StFlush;
            halted_q <= 1'b0;
          end
        end
        StFlush: begin
          if (flush_done) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StRun;
          ready_q  <= 1'b1;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  err_log_fifo #(
    .Depth (LOG_DEPTH),
    .Width (EW)
  ) u_err_log_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_done),
    .push  (s2_err),
    .pop   (log_rd_en),
    .wdata (log_wdata),
    .rdata (log_rd_data),
    .empty (log_empty),
    .full  (log_full),
    .ovf   (log_ovf)
  );

  assign in_ready = ready_q;
  assign halted   = halted_q;
  assign pass_cnt = pass_q;
  assign err_cnt  = err_q;

endmodule
